// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit period and the
// receiver state encoding. The transmit stage imports the same package.
package uart_pkg;

    localparam int UART_BITS      = 8;
    localparam int UART_T_DEFAULT = 2604;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // True when the given data-bit index is the last bit of the frame.
    function automatic logic is_last_bit(input logic [2:0] idx);
        return (idx == 3'(UART_BITS - 1));
    endfunction

endpackage

// File: rtl/uart_receiver_sync2.sv
// Two-flop synchroniser for a single asynchronous input. The reset value
// is a parameter so an idle-high line does not look active out of reset.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Capture the asynchronous input and let the first stage settle for a cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage. Samples each bit in its middle using a cycle
// counter of T clocks per bit, holds one received byte behind a
// valid/ready handshake and flags framing errors and overruns as
// single-cycle pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int T = UART_T_DEFAULT
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       UART_RX,
    output logic [7:0] data_out,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int              CW        = $clog2(T) + 1;
    localparam logic [CW-1:0]   HALF_LAST = CW'(T / 2 - 1);
    localparam logic [CW-1:0]   FULL_LAST = CW'(T - 1);

    logic            w_rx_s;
    rx_state_t       r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bitidx;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_frame_err;
    logic            r_overrun;

    sync2 #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .i_clk   (CLK),
        .i_rst_n (RSTN),
        .i_d     (UART_RX),
        .o_q     (w_rx_s)
    );

    // Receive FSM, bit sampling, holding register and error pulses.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bitidx    <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            // Pulses are low unless an event below raises them this cycle.
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            // Consumption drops valid; a delivery in STOP overrides this.
            if (r_valid && ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= START;
                    end
                end

                START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            // Start bit did not last half a bit: glitch.
                            r_state <= IDLE;
                        end else begin
                            r_state  <= DATA;
                            r_bitidx <= 3'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt             <= '0;
                        r_shift[r_bitidx] <= w_rx_s;
                        if (is_last_bit(r_bitidx)) begin
                            r_state  <= STOP;
                            r_bitidx <= 3'd0;
                        end else begin
                            r_bitidx <= r_bitidx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                STOP: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            // Re-arm at mid stop bit so a following start
                            // edge is seen without delay.
                            r_state <= IDLE;
                            if (!r_valid || ready) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                BREAK: begin
                    // A held-low line reports one error, then waits here.
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    r_cnt    <= '0;
                    r_bitidx <= 3'd0;
                end
            endcase
        end
    end

    assign data_out  = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- 8N1 UART receive stage. It deserialises the incoming UART_RX line into bytes for the core; it is the counterpart of the transmit stage and uses the same bit-period parameter T.
- Received bytes sit in a one-entry holding register behind a valid/ready handshake.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- T, 2604: CLK cycles per bit period. Legal range is T >= 4. T/2 means integer division.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RSTN  in  1  asynchronous active-low reset.
- UART_RX  in  1  serial input, asynchronous to CLK, idles high.
- data_out  out  8  received byte, LSB = first data bit on the wire.
- valid  out  1  data_out holds an unconsumed byte.
- ready  in  1  consumer accepts data_out when valid && ready at a posedge.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: a good byte was dropped because the holding register was full.

Behaviour:
- Reset (RSTN=0, asynchronous):
  - state=IDLE, bit counter=0, cycle counter=0, shift register=0.
  - sync flops=1 (rx_s=1).
  - data_out=0, valid=0, frame_err=0, overrun=0.
  - Reset mid-frame abandons the frame silently; no pulses are produced.
- Input synchroniser: UART_RX passes through a 2-flop synchroniser, reset value 1. All logic below uses only its output rx_s.
- Cycle counter: width $clog2(T)+1. It is cleared on every state entry and on every sample point.
- IDLE:
  - rx_s==0 -> START, cnt=0.
- START:
  - cnt increments each cycle.
  - At cnt==T/2-1, sample rx_s. If 1 (glitch), go to IDLE with no pulse. If 0, go to DATA with bitidx=0, cnt=0.
- DATA:
  - At cnt==T-1, shift rx_s into bit[bitidx], LSB first. Then cnt=0 and bitidx++.
  - After bitidx 7 is sampled -> STOP.
- STOP:
  - At cnt==T-1, sample rx_s.
  - If 1: deliver the byte (see below) and go to IDLE on the next cycle. The receiver re-arms half a bit early so that back-to-back frames are caught.
  - If 0: frame_err=1 for exactly one cycle, discard the byte, go to BREAK.
- BREAK:
  - Wait for rx_s==1, then go to IDLE.
  - A line held low does not produce repeated errors.
- Delivery, evaluated on the stop-sample cycle:
  - valid==0: data_out<=byte, valid<=1 on the next cycle.
  - valid==1 && ready==1 (simultaneous consume): data_out<=new byte, valid stays 1, no overrun.
  - valid==1 && ready==0: new byte dropped, data_out unchanged, overrun=1 for one cycle.
- Handshake:
  - valid falls the cycle after a valid && ready posedge, unless refilled as above.
  - data_out is stable while valid=1 and ready=0.
- Latency: valid rises 2 + T/2 + 9*T + 1 cycles after the UART_RX falling edge, ±1 cycle of synchroniser phase.
- frame_err and overrun are registered outputs, 0 except on their pulse cycle. The two can never pulse in the same cycle.

Decomposition:
- Shared package uart_pkg holds:
  - UART_BITS=8 and the default T=2604, shared with the transmitter.
  - typedef enum logic[2:0] rx_state_t {IDLE, START, DATA, STOP, BREAK}.
- Natural sub-module: sync2 (2-flop synchroniser with a reset value parameter), reusable for other asynchronous inputs.
- Everything else stays in uart_receiver.

Test Plan:
- T=16. Send 0xA5 with correct framing, ready=1 -> data_out=0xA5. valid pulses 1 cycle at 2+8+144+1 (±1) cycles after the start edge. No error pulses.
- T=16, ready=0. Send 0x3C, then 0x81 back-to-back -> data_out stays 0x3C, valid held. overrun pulses once at the second stop sample. Raising ready then drops valid with no new byte.
- T=16. Send 0x55 with the stop bit driven 0, and hold the line low 40 cycles -> exactly one frame_err pulse, valid stays 0. After the line returns high, 0x12 is received correctly.
- T=16. Drive a 3-cycle low glitch on an idle line -> no valid, no frame_err. State returns to IDLE, and a following 0xFF is received.
- T=16. Assert RSTN low mid-DATA of 0x77 -> all outputs 0 during reset, no pulses. A subsequent 0x0F is received correctly.
- T=16, ready=1 throughout. Send 0x01, 0x02 back-to-back with zero idle gap -> two valid pulses with data 0x01 then 0x02, no overrun.
